// File: rtl/riscv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : riscv_pkg
// Description : Shared constants and types for the instruction fetch path:
//               datapath width, default reset vector, fetch FSM state
//               encoding and the canonical NOP encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package riscv_pkg;

   localparam int          XLEN                 = 32;
   localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;
   localparam logic [31:0] INSTR_NOP            = 32'h0000_0013;  // addi x0,x0,0

   // Fetch FSM states:
   //   S_ISSUE - request outstanding on the memory bus, waiting for gnt
   //   S_WAIT  - request granted, waiting for rvalid
   //   S_HOLD  - instruction buffered, waiting for decode to accept it
   typedef enum logic [1:0] {
      S_ISSUE = 2'd0,
      S_WAIT  = 2'd1,
      S_HOLD  = 2'd2
   } fetch_state_e;

endpackage : riscv_pkg
`default_nettype wire

// File: rtl/fetch_out_buf.sv
`default_nettype none
// ============================================================================
// Module      : fetch_out_buf
// Description : Single-entry valid/ready holding register for {pc, instr}.
//               Flush has priority over load; load has priority over the
//               downstream handshake. Data only changes on load, so the
//               outputs are stable while out_valid=1 and out_ready=0.
// Ports       : clk, rst         - clock, asynchronous active-high reset
//               load, load_pc,
//               load_instr       - capture a new entry (sets out_valid)
//               flush            - drop the entry (clears out_valid)
//               out_valid/ready  - downstream handshake
//               out_pc/out_instr - buffered entry
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_out_buf
   import riscv_pkg::*;
#(
   parameter int WIDTH = XLEN
)(
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic             flush,
   input  logic [WIDTH-1:0] load_pc,
   input  logic [WIDTH-1:0] load_instr,
   input  logic             out_ready,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_pc,
   output logic [WIDTH-1:0] out_instr
);

   logic             r_valid;
   logic [WIDTH-1:0] r_pc;
   logic [WIDTH-1:0] r_instr;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_valid <= 1'b0;
         r_pc    <= '0;
         r_instr <= '0;
      end else begin
         if (flush) begin
            r_valid <= 1'b0;
         end else if (load) begin
            r_valid <= 1'b1;
            r_pc    <= load_pc;
            r_instr <= load_instr;
         end else if (r_valid && out_ready) begin
            r_valid <= 1'b0;
         end
      end
   end

   assign out_valid = r_valid;
   assign out_pc    = r_pc;
   assign out_instr = r_instr;

endmodule : fetch_out_buf
`default_nettype wire

// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch_unit
// Description : Owns the program counter, issues instruction-memory reads
//               over a req/gnt/rvalid bus (one outstanding request) and
//               presents {pc, instr} to decode over valid/ready. Redirects
//               reload the PC and discard any stale in-flight fetch.
// Ports       : clk, rst             - clock, asynchronous active-high reset
//               imem_req/addr/gnt    - memory request channel
//               imem_rvalid/rdata    - memory response channel
//               redirect_valid/pc    - branch/jump redirect pulse
//               if_valid/ready       - decode handshake
//               if_pc/if_instr       - fetched instruction and its address
// Revision    : 1.0 - initial release
// ============================================================================
module instr_fetch_unit
   import riscv_pkg::*;
#(
   parameter int             XLEN         = riscv_pkg::XLEN,
   parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(DEFAULT_RESET_VECTOR)
)(
   input  logic            clk,
   input  logic            rst,
   output logic            imem_req,
   output logic [XLEN-1:0] imem_addr,
   input  logic            imem_gnt,
   input  logic            imem_rvalid,
   input  logic [XLEN-1:0] imem_rdata,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   output logic            if_valid,
   input  logic            if_ready,
   output logic [XLEN-1:0] if_pc,
   output logic [XLEN-1:0] if_instr
);

   localparam logic [XLEN-1:0] c_PC_STEP    = XLEN'(4);
   localparam logic [XLEN-1:0] c_ALIGN_MASK = XLEN'(3);

   fetch_state_e    r_state;
   fetch_state_e    w_state_nxt;
   logic [XLEN-1:0] r_pc;
   logic [XLEN-1:0] w_pc_nxt;
   logic [XLEN-1:0] r_req_pc;      // address of the granted request
   logic [XLEN-1:0] w_req_pc_nxt;
   logic            r_drop;        // next response belongs to a stale request
   logic            w_drop_nxt;
   logic            w_buf_load;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state  <= S_ISSUE;
         r_pc     <= RESET_VECTOR;
         r_req_pc <= '0;
         r_drop   <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_pc     <= w_pc_nxt;
         r_req_pc <= w_req_pc_nxt;
         r_drop   <= w_drop_nxt;
      end
   end

   always_comb begin
      w_state_nxt  = r_state;
      w_pc_nxt     = r_pc;
      w_req_pc_nxt = r_req_pc;
      w_drop_nxt   = r_drop;
      w_buf_load   = 1'b0;

      case (r_state)
         S_ISSUE: begin
            if (imem_gnt) begin
               w_pc_nxt     = r_pc + c_PC_STEP;
               w_req_pc_nxt = r_pc;
               w_state_nxt  = S_WAIT;
               // The request just granted targets the old path; its
               // response must be thrown away.
               if (redirect_valid) begin
                  w_drop_nxt = 1'b1;
               end
            end
         end
         S_WAIT: begin
            if (imem_rvalid) begin
               if (r_drop) begin
                  w_drop_nxt  = 1'b0;
                  w_state_nxt = S_ISSUE;
               end else if (redirect_valid) begin
                  // Response arrives with the redirect: discard it directly
                  // instead of arming drop for a response that never comes.
                  w_state_nxt = S_ISSUE;
               end else begin
                  w_buf_load  = 1'b1;
                  w_state_nxt = S_HOLD;
               end
            end else if (redirect_valid) begin
               w_drop_nxt = 1'b1;
            end
         end
         S_HOLD: begin
            if (redirect_valid || (if_valid && if_ready)) begin
               w_state_nxt = S_ISSUE;
            end
         end
         default: begin
            w_state_nxt = S_ISSUE;
         end
      endcase

      if (redirect_valid) begin
         w_pc_nxt = redirect_pc & ~c_ALIGN_MASK;
      end
   end

   // Request comes from registered state only; rst masks it while the
   // asynchronous reset holds the FSM in S_ISSUE.
   assign imem_req  = (r_state == S_ISSUE) && !rst;
   assign imem_addr = r_pc;

   fetch_out_buf #(
      .WIDTH      (XLEN)
   ) u_out_buf (
      .clk        (clk),
      .rst        (rst),
      .load       (w_buf_load),
      .flush      (redirect_valid),
      .load_pc    (r_req_pc),
      .load_instr (imem_rdata),
      .out_ready  (if_ready),
      .out_valid  (if_valid),
      .out_pc     (if_pc),
      .out_instr  (if_instr)
   );

endmodule : instr_fetch_unit
`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_fetch_unit
// Description : Self-checking bench for instr_fetch_unit. A behavioural
//               memory answers requests; expected {pc, instr} pairs are
//               queued by each scenario and popped on decode handshakes.
//               A second instance checks a non-zero reset vector with wrap.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_fetch_unit;
   import riscv_pkg::*;

   localparam int W = 32;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         imem_req;
   logic [W-1:0] imem_addr;
   logic         imem_gnt = 1'b0;
   logic         imem_rvalid = 1'b0;
   logic [W-1:0] imem_rdata = 32'hBAD0_0000;
   logic         redirect_valid = 1'b0;
   logic [W-1:0] redirect_pc = '0;
   logic         if_valid;
   logic         if_ready = 1'b0;
   logic [W-1:0] if_pc;
   logic [W-1:0] if_instr;

   // second instance: RESET_VECTOR near the top of the address space
   logic         imem_req2;
   logic [W-1:0] imem_addr2;
   logic         imem_gnt2 = 1'b1;
   logic         imem_rvalid2 = 1'b0;
   logic [W-1:0] imem_rdata2 = 32'hBAD0_0000;
   logic         redirect_valid2 = 1'b0;
   logic [W-1:0] redirect_pc2 = '0;
   logic         if_valid2;
   logic         if_ready2 = 1'b1;
   logic [W-1:0] if_pc2;
   logic [W-1:0] if_instr2;

   int n_checks = 0;
   int n_fail   = 0;

   logic [W-1:0] exp_q[$];     // scoreboard: expected if_pc, in order
   logic [W-1:0] gnt_log[$];   // addresses granted by the memory model
   logic [W-1:0] log2_addr[$];
   logic [W-1:0] log2_pc[$];
   logic [W-1:0] log2_instr[$];

   bit           gnt_en   = 1'b0;
   int           rv_delay = 1;
   bit           pend     = 1'b0;
   int           pend_cnt = 0;
   logic [W-1:0] pend_addr = '0;
   bit           pend2    = 1'b0;
   logic [W-1:0] pend_addr2 = '0;

   always #5 clk = ~clk;

   instr_fetch_unit u_dut (
      .clk            (clk),
      .rst            (rst),
      .imem_req       (imem_req),
      .imem_addr      (imem_addr),
      .imem_gnt       (imem_gnt),
      .imem_rvalid    (imem_rvalid),
      .imem_rdata     (imem_rdata),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .if_valid       (if_valid),
      .if_ready       (if_ready),
      .if_pc          (if_pc),
      .if_instr       (if_instr)
   );

   instr_fetch_unit #(
      .RESET_VECTOR   (32'hFFFF_FFF8)
   ) u_dut_rv (
      .clk            (clk),
      .rst            (rst),
      .imem_req       (imem_req2),
      .imem_addr      (imem_addr2),
      .imem_gnt       (imem_gnt2),
      .imem_rvalid    (imem_rvalid2),
      .imem_rdata     (imem_rdata2),
      .redirect_valid (redirect_valid2),
      .redirect_pc    (redirect_pc2),
      .if_valid       (if_valid2),
      .if_ready       (if_ready2),
      .if_pc          (if_pc2),
      .if_instr       (if_instr2)
   );

   function automatic logic [W-1:0] mem_word(input logic [W-1:0] a);
      return INSTR_NOP ^ (a << 8);
   endfunction

   // Memory model for the main instance: drives 2 time units after negedge.
   always @(negedge clk) begin
      #2;
      imem_rvalid = 1'b0;
      imem_rdata  = 32'hBAD0_0000;
      if (pend) begin
         if (pend_cnt == 0) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mem_word(pend_addr);
            pend        = 1'b0;
         end else begin
            pend_cnt--;
         end
      end
      imem_gnt = 1'b0;
      if (gnt_en && imem_req && !pend) begin
         imem_gnt  = 1'b1;
         pend      = 1'b1;
         pend_addr = imem_addr;
         pend_cnt  = rv_delay - 1;
         gnt_log.push_back(imem_addr);
      end
   end

   // Scoreboard monitor: a handshake that coincides with a redirect is discarded.
   always @(negedge clk) begin
      logic [W-1:0] e;
      #2;
      if (!rst && if_valid && if_ready && !redirect_valid) begin
         n_checks++;
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL sb_unexpected: got if_pc=%h, expected no output", if_pc);
         end else begin
            e = exp_q.pop_front();
            if (if_pc !== e) begin
               n_fail++;
               $display("FAIL sb_pc: got %h, expected %h", if_pc, e);
            end
            n_checks++;
            if (if_instr !== mem_word(e)) begin
               n_fail++;
               $display("FAIL sb_instr: got %h, expected %h", if_instr, mem_word(e));
            end
         end
      end
   end

   // Memory model + logger for the reset-vector instance (gnt tied high).
   always @(negedge clk) begin
      #2;
      imem_rvalid2 = 1'b0;
      imem_rdata2  = 32'hBAD0_0000;
      if (pend2) begin
         imem_rvalid2 = 1'b1;
         imem_rdata2  = mem_word(pend_addr2);
         pend2        = 1'b0;
      end
      if (!rst && imem_req2) begin
         pend2      = 1'b1;
         pend_addr2 = imem_addr2;
         if (log2_addr.size() < 3) log2_addr.push_back(imem_addr2);
      end
      if (!rst && if_valid2 && log2_pc.size() < 3) begin
         log2_pc.push_back(if_pc2);
         log2_instr.push_back(if_instr2);
      end
   end

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic wait_fetches(input int n, input string name);
      for (int i = 0; i < 60; i++) begin
         step();
         if (gnt_log.size() >= n) gnt_en = 1'b0;
         if (gnt_log.size() >= n && exp_q.size() == 0) break;
      end
      n_checks++;
      if (gnt_log.size() < n || exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL %s_timeout: grants=%0d pending=%0d, expected grants=%0d pending=0",
                  name, gnt_log.size(), exp_q.size(), n);
      end
      gnt_en = 1'b0;
   endtask

   task automatic test_reset();
      step();
      step();
      n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL rst_req: got %b, expected 0", imem_req); end
      n_checks++; if (if_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b, expected 0", if_valid); end
      n_checks++; if (if_pc !== 32'h0) begin n_fail++; $display("FAIL rst_pc: got %h, expected 0", if_pc); end
      n_checks++; if (if_instr !== 32'h0) begin n_fail++; $display("FAIL rst_instr: got %h, expected 0", if_instr); end
      n_checks++; if (imem_addr !== 32'h0) begin n_fail++; $display("FAIL rst_addr: got %h, expected 0", imem_addr); end
      n_checks++; if (imem_addr2 !== 32'hFFFF_FFF8) begin n_fail++; $display("FAIL rst_addr_rv: got %h, expected fffffff8", imem_addr2); end
      rst = 1'b0;
   endtask

   task automatic test_sequential();
      gnt_log.delete();
      exp_q.push_back(32'h0);
      exp_q.push_back(32'h4);
      exp_q.push_back(32'h8);
      if_ready = 1'b1;
      gnt_en   = 1'b1;
      wait_fetches(3, "seq");
      for (int i = 0; i < 3; i++) begin
         n_checks++;
         if (i >= gnt_log.size() || gnt_log[i] !== 32'(4 * i)) begin
            n_fail++;
            $display("FAIL seq_addr%0d: got %h, expected %h", i,
                     (i < gnt_log.size()) ? gnt_log[i] : 32'hXXXX_XXXX, 32'(4 * i));
         end
      end
   endtask

   task automatic test_backpressure();
      gnt_log.delete();
      if_ready = 1'b0;
      gnt_en   = 1'b1;
      exp_q.push_back(32'hC);
      for (int i = 0; i < 20 && !if_valid; i++) begin
         step();
         if (gnt_log.size() >= 1) gnt_en = 1'b0;
      end
      gnt_en = 1'b0;
      n_checks++; if (if_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid: got %b, expected 1", if_valid); end
      for (int c = 0; c < 5; c++) begin
         n_checks++; if (if_pc !== 32'hC) begin n_fail++; $display("FAIL bp_pc%0d: got %h, expected 0000000c", c, if_pc); end
         n_checks++; if (if_instr !== mem_word(32'hC)) begin n_fail++; $display("FAIL bp_instr%0d: got %h, expected %h", c, if_instr, mem_word(32'hC)); end
         n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL bp_req%0d: got %b, expected 0", c, imem_req); end
         step();
      end
      if_ready = 1'b1;
      gnt_en   = 1'b1;
      exp_q.push_back(32'h10);
      wait_fetches(2, "bp");
      n_checks++;
      if (gnt_log.size() != 2 || gnt_log[0] !== 32'hC || gnt_log[1] !== 32'h10) begin
         n_fail++;
         $display("FAIL bp_grants: got %0d grants, expected exactly 0000000c,00000010", gnt_log.size());
      end
   endtask

   task automatic test_redirect_wait();
      // steer PC to 8 from S_ISSUE with no grant outstanding
      redirect_valid = 1'b1;
      redirect_pc    = 32'h8;
      step();
      redirect_valid = 1'b0;
      n_checks++; if (imem_addr !== 32'h8) begin n_fail++; $display("FAIL rw_addr8: got %h, expected 00000008", imem_addr); end
      rv_delay = 3;
      gnt_log.delete();
      gnt_en = 1'b1;
      for (int i = 0; i < 10; i++) begin
         step();
         if (gnt_log.size() >= 1) break;
      end
      gnt_en = 1'b0;
      // now in S_WAIT for addr 8: two redirects before the response returns
      redirect_valid = 1'b1;
      redirect_pc    = 32'h80;
      step();
      redirect_pc    = 32'h100;
      step();
      redirect_valid = 1'b0;
      n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL rw_req_wait: got %b, expected 0", imem_req); end
      step();
      n_checks++; if (if_valid !== 1'b0) begin n_fail++; $display("FAIL rw_dropped: got if_valid=%b, expected 0", if_valid); end
      n_checks++; if (imem_addr !== 32'h100) begin n_fail++; $display("FAIL rw_addr: got %h, expected 00000100", imem_addr); end
      n_checks++; if (imem_req !== 1'b1) begin n_fail++; $display("FAIL rw_req: got %b, expected 1", imem_req); end
      rv_delay = 1;
      gnt_en   = 1'b1;
      exp_q.push_back(32'h100);
      wait_fetches(2, "rw");
      n_checks++;
      if (gnt_log.size() < 2 || gnt_log[1] !== 32'h100) begin
         n_fail++;
         $display("FAIL rw_grant: got %0d grants, expected second grant at 00000100", gnt_log.size());
      end
   endtask

   task automatic test_redirect_gnt();
      gnt_log.delete();
      if_ready = 1'b0;
      gnt_en   = 1'b1;
      for (int i = 0; i < 20 && !if_valid; i++) begin
         step();
         if (gnt_log.size() >= 1) gnt_en = 1'b0;
      end
      gnt_en = 1'b0;
      n_checks++; if (if_pc !== 32'h104) begin n_fail++; $display("FAIL rg_held_pc: got %h, expected 00000104", if_pc); end
      // handshake offered together with a redirect: not consumed
      if_ready       = 1'b1;
      redirect_valid = 1'b1;
      redirect_pc    = 32'h203;
      step();
      redirect_valid = 1'b0;
      n_checks++; if (if_valid !== 1'b0) begin n_fail++; $display("FAIL rg_flush: got if_valid=%b, expected 0", if_valid); end
      n_checks++; if (imem_addr !== 32'h200) begin n_fail++; $display("FAIL rg_addr: got %h, expected 00000200", imem_addr); end
      n_checks++; if (imem_req !== 1'b1) begin n_fail++; $display("FAIL rg_req: got %b, expected 1", imem_req); end
      // redirect in the same cycle as the grant: that response is stale
      gnt_en         = 1'b1;
      redirect_valid = 1'b1;
      redirect_pc    = 32'h203;
      step();
      redirect_valid = 1'b0;
      n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL rg_wait: got %b, expected 0", imem_req); end
      exp_q.push_back(32'h200);
      wait_fetches(3, "rg");
      n_checks++;
      if (gnt_log.size() != 3 || gnt_log[1] !== 32'h200 || gnt_log[2] !== 32'h200) begin
         n_fail++;
         $display("FAIL rg_grants: got %0d grants, expected 00000104,00000200,00000200", gnt_log.size());
      end
   endtask

   task automatic test_reset_vector();
      logic [W-1:0] exp_a [3];
      exp_a[0] = 32'hFFFF_FFF8;
      exp_a[1] = 32'hFFFF_FFFC;
      exp_a[2] = 32'h0000_0000;
      for (int i = 0; i < 3; i++) begin
         n_checks++;
         if (i >= log2_addr.size() || log2_addr[i] !== exp_a[i]) begin
            n_fail++;
            $display("FAIL rv_addr%0d: got %0d logged, expected %h", i, log2_addr.size(), exp_a[i]);
         end
         n_checks++;
         if (i >= log2_pc.size() || log2_pc[i] !== exp_a[i] || log2_instr[i] !== mem_word(exp_a[i])) begin
            n_fail++;
            $display("FAIL rv_out%0d: got %0d logged, expected pc %h instr %h", i, log2_pc.size(), exp_a[i], mem_word(exp_a[i]));
         end
      end
   endtask

   task automatic test_reset_midflight();
      rv_delay = 4;
      gnt_log.delete();
      if_ready = 1'b1;
      gnt_en   = 1'b1;
      for (int i = 0; i < 10; i++) begin
         step();
         if (gnt_log.size() >= 1) break;
      end
      gnt_en = 1'b0;
      rst    = 1'b1;
      #1;
      n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL mr_req_rst: got %b, expected 0", imem_req); end
      n_checks++; if (imem_addr !== 32'h0) begin n_fail++; $display("FAIL mr_addr_rst: got %h, expected 0", imem_addr); end
      step();
      rst = 1'b0;
      for (int c = 0; c < 3; c++) begin
         step();
         n_checks++; if (if_valid !== 1'b0) begin n_fail++; $display("FAIL mr_valid%0d: got %b, expected 0", c, if_valid); end
         n_checks++; if (imem_addr !== 32'h0 || imem_req !== 1'b1) begin
            n_fail++; $display("FAIL mr_issue%0d: got addr %h req %b, expected 0 and 1", c, imem_addr, imem_req);
         end
      end
      rv_delay = 1;
      gnt_en   = 1'b1;
      exp_q.push_back(32'h0);
      wait_fetches(2, "mr");
      n_checks++;
      if (gnt_log.size() < 2 || gnt_log[1] !== 32'h0) begin
         n_fail++;
         $display("FAIL mr_grant: got %0d grants, expected second grant at 00000000", gnt_log.size());
      end
   endtask

   initial begin
      test_reset();
      test_sequential();
      test_backpressure();
      test_redirect_wait();
      test_redirect_gnt();
      test_reset_vector();
      test_reset_midflight();
      step();
      step();
      n_checks++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL sb_drain: got %0d pending, expected 0", exp_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule : tb_instr_fetch_unit
`default_nettype wire
